// File: rtl/wrapper_risc.sv
// Demo top: single-cycle 16-bit RISC core with a bubble-sort program ROM and data RAM.
// After the core halts, button presses step an index through the sorted array and the word is shown on out.
module wrapper_risc #(
    parameter int N_ELEM   = 10,
    parameter int DM_DEPTH = 16,
    parameter int IM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button,
    output logic [15:0] out
);
    localparam int PW  = $clog2(IM_DEPTH);
    localparam int DAW = $clog2(DM_DEPTH);
    localparam int IW  = $clog2(N_ELEM);

    localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_ADDI = 4'h2, OP_LW = 4'h3,
                           OP_SW   = 4'h4, OP_BLTU = 4'h5, OP_BNE = 4'h6, OP_J = 4'h7,
                           OP_HALT = 4'hF;

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [5:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // R1 = outer bound, R2 = j, R3/R4 = DM[j]/DM[j+1]; swap when DM[j+1] < DM[j]
    function automatic logic [15:0] rom(input logic [PW-1:0] a);
        case (int'(a))
            0:       return ins(OP_ADDI, 3'd1, 3'd0, 6'(N_ELEM - 1));
            1:       return ins(OP_ADDI, 3'd2, 3'd0, 6'd0);
            2:       return ins(OP_LW,   3'd3, 3'd2, 6'd0);
            3:       return ins(OP_LW,   3'd4, 3'd2, 6'd1);
            4:       return ins(OP_BLTU, 3'd4, 3'd3, 6'd1);
            5:       return ins(OP_J,    3'd0, 3'd0, 6'd2);
            6:       return ins(OP_SW,   3'd4, 3'd2, 6'd0);
            7:       return ins(OP_SW,   3'd3, 3'd2, 6'd1);
            8:       return ins(OP_ADDI, 3'd2, 3'd2, 6'd1);
            9:       return ins(OP_BNE,  3'd2, 3'd1, 6'h38);
            10:      return ins(OP_ADDI, 3'd1, 3'd1, 6'h3F);
            11:      return ins(OP_BNE,  3'd1, 3'd0, 6'h35);
            12:      return ins(OP_HALT, 3'd0, 3'd0, 6'd0);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] dm_init(input int i);
        case (i)
            0:       return 16'h0032;
            1:       return 16'h0007;
            2:       return 16'h01F4;
            3:       return 16'h0000;
            4:       return 16'hFFFF;
            5:       return 16'h0019;
            6:       return 16'h0007;
            7:       return 16'h8000;
            8:       return 16'h0064;
            9:       return 16'h0003;
            default: return 16'h0000;
        endcase
    endfunction

    logic [PW-1:0]  pc;
    logic           halted;
    logic [15:0]    rf [8];
    logic [15:0]    dm [DM_DEPTH];
    logic [IW-1:0]  idx;
    logic [1:0]     sync;
    logic           prev;

    logic [15:0]    instr, imm16, rd_v, rs_v, rt_v, ea, wr_data;
    logic [3:0]     op;
    logic [2:0]     rd, rs, rt;
    logic           wr_en, dm_we, do_halt;
    logic [DAW-1:0] dm_addr;
    logic [PW-1:0]  pc_inc, pc_nx;
    logic           rise;
    logic [IW-1:0]  idx_n;

    always_comb begin
        instr   = rom(pc);
        op      = instr[15:12];
        rd      = instr[11:9];
        rs      = instr[8:6];
        rt      = instr[5:3];
        imm16   = {{10{instr[5]}}, instr[5:0]};
        rd_v    = (rd == 3'd0) ? 16'h0000 : rf[rd];
        rs_v    = (rs == 3'd0) ? 16'h0000 : rf[rs];
        rt_v    = (rt == 3'd0) ? 16'h0000 : rf[rt];
        ea      = rs_v + imm16;
        dm_addr = ea[DAW-1:0];
        pc_inc  = pc + PW'(1);
        pc_nx   = pc_inc;
        wr_en   = 1'b0;
        wr_data = 16'h0000;
        dm_we   = 1'b0;
        do_halt = 1'b0;
        case (op)
            OP_ADD:  begin wr_en = 1'b1; wr_data = rs_v + rt_v; end
            OP_SUB:  begin wr_en = 1'b1; wr_data = rs_v - rt_v; end
            OP_ADDI: begin wr_en = 1'b1; wr_data = ea; end
            OP_LW:   begin wr_en = 1'b1; wr_data = dm[dm_addr]; end
            OP_SW:   dm_we = 1'b1;
            OP_BLTU: if (rd_v < rs_v)  pc_nx = pc_inc + imm16[PW-1:0];
            OP_BNE:  if (rd_v != rs_v) pc_nx = pc_inc + imm16[PW-1:0];
            OP_J:    pc_nx = pc_inc + imm16[PW-1:0];
            OP_HALT: begin do_halt = 1'b1; pc_nx = pc; end
            default: ;
        endcase
    end

    // Edge detection runs all the time so a button already high at halt does not count as a press
    always_comb begin
        rise  = sync[1] & ~prev;
        idx_n = idx;
        if (rise)
            idx_n = (idx == IW'(N_ELEM - 1)) ? '0 : idx + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= '0;
            halted <= 1'b0;
            idx    <= '0;
            out    <= 16'h0000;
            sync   <= 2'b00;
            prev   <= 1'b0;
            for (int i = 0; i < 8; i++)        rf[i] <= 16'h0000;
            for (int i = 0; i < DM_DEPTH; i++) dm[i] <= dm_init(i);
        end else begin
            sync <= {sync[0], button};
            prev <= sync[1];
            if (!halted) begin
                pc  <= pc_nx;
                out <= 16'h0000;
                if (do_halt)            halted <= 1'b1;
                if (wr_en && rd != 3'd0) rf[rd] <= wr_data;
                if (dm_we)              dm[dm_addr] <= rd_v;
            end else begin
                idx <= idx_n;
                out <= dm[DAW'(idx_n)];
            end
        end
    end
endmodule

// File: tb/tb_wrapper_risc.sv
// Directed bench for wrapper_risc: sort result, button stepping/wrap, held button, ignored presses, resets.
module tb_wrapper_risc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        button = 1'b0;
    logic [15:0] out;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] sorted [10];
    logic [15:0] init_v [10];

    wrapper_risc dut (.clk(clk), .rst(rst), .button(button), .out(out));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic wait_halt();
        int n;
        n = 0;
        while (dut.halted !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("halt_within_2000", 16'(dut.halted), 16'h0001);
        cycles(2);
    endtask

    task automatic press();
        button = 1'b1;
        cycles(5);
        button = 1'b0;
        cycles(5);
    endtask

    task automatic chk_sorted(input string tag);
        for (int i = 0; i < 10; i++)
            chk($sformatf("%s_dm%0d", tag, i), dut.dm[i], sorted[i]);
    endtask

    initial begin
        sorted = '{16'h0000, 16'h0003, 16'h0007, 16'h0007, 16'h0019,
                   16'h0032, 16'h0064, 16'h01F4, 16'h8000, 16'hFFFF};
        init_v = '{16'h0032, 16'h0007, 16'h01F4, 16'h0000, 16'hFFFF,
                   16'h0019, 16'h0007, 16'h8000, 16'h0064, 16'h0003};

        // reset state
        cycles(2);
        chk("rst_out", out, 16'h0000);
        chk("rst_halted", 16'(dut.halted), 16'h0000);
        chk("rst_pc", 16'(dut.pc), 16'h0000);
        chk("rst_dm0", dut.dm[0], init_v[0]);
        chk("rst_dm9", dut.dm[9], init_v[9]);
        rst = 1'b0;

        // test 1: sort runs to halt, untouched upper words
        cycles(5000);
        chk("t1_halted", 16'(dut.halted), 16'h0001);
        chk("t1_out", out, 16'h0000);
        chk_sorted("t1");
        for (int i = 10; i < 16; i++)
            chk($sformatf("t1_dm%0d", i), dut.dm[i], 16'h0000);

        // test 2/3: step through and wrap, 20 presses total
        for (int i = 1; i <= 20; i++) begin
            press();
            chk($sformatf("t2_press%0d", i), out, sorted[i % 10]);
        end

        // test 4: held button is a single step
        do_reset();
        wait_halt();
        button = 1'b1;
        cycles(50);
        chk("t4_held", out, 16'h0003);
        button = 1'b0;
        cycles(10);
        chk("t4_release", out, 16'h0003);

        // test 5: presses during sort are ignored
        do_reset();
        cycles(20);
        press();
        press();
        chk("t5_mid_out", out, 16'h0000);
        chk("t5_mid_idx", 16'(dut.idx), 16'h0000);
        wait_halt();
        chk("t5_halt_out", out, 16'h0000);
        press();
        chk("t5_first", out, 16'h0003);

        // test 6: reset mid-sort restarts from initial data
        do_reset();
        cycles(100);
        chk("t6_not_halted", 16'(dut.halted), 16'h0000);
        do_reset();
        chk("t6_reload_dm0", dut.dm[0], init_v[0]);
        chk("t6_reload_dm4", dut.dm[4], init_v[4]);
        wait_halt();
        chk_sorted("t6");
        repeat (4) press();
        chk("t6_idx4_out", out, 16'h0019);
        chk("t6_idx4", 16'(dut.idx), 16'h0004);
        do_reset();
        chk("t6_rst_out", out, 16'h0000);
        chk("t6_rst_idx", 16'(dut.idx), 16'h0000);
        chk("t6_rst_halted", 16'(dut.halted), 16'h0000);
        wait_halt();
        chk_sorted("t6b");
        chk("t6b_out", out, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
